// File: rtl/led_pkg.sv
// Shared mode encoding and timing constants for the multi-channel LED controller.
package led_pkg;
    localparam logic [2:0] MODE_OFF  = 3'd0;
    localparam logic [2:0] MODE_ON   = 3'd1;
    localparam logic [2:0] MODE_SLOW = 3'd2;
    localparam logic [2:0] MODE_FAST = 3'd3;
    localparam logic [2:0] MODE_CODE = 3'd4;
    localparam logic [2:0] MODE_ACT  = 3'd5;

    localparam int SLOW_TICKS = 5;
    localparam int TICK_HZ    = 10;
endpackage

// File: rtl/led_channel.sv
// One LED channel: mode tracking plus phase, burst and hold counters, all stepped by the shared tick.
// The lit output is the next-state value so the pin register in the top gives one clock of latency.
module led_channel
    import led_pkg::*;
#(
    parameter int HOLD_TICKS = 2,
    parameter int GAP_TICKS  = 10
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       tick,
    input  logic [2:0] mode,
    input  logic [3:0] code,
    input  logic       trigger,
    output logic       lit
);
    localparam int PW = 6;
    localparam logic [PW-1:0] SLOW_LAST = PW'(SLOW_TICKS - 1);
    localparam logic [PW-1:0] GAP_M1    = PW'(GAP_TICKS - 1);
    localparam logic [3:0]    HOLD      = 4'(HOLD_TICKS);

    logic [2:0]    mode_q;
    logic [PW-1:0] phase_q, phase_d;
    logic [3:0]    code_q, code_d;
    logic [3:0]    hold_q, hold_d;
    logic          lit_q;
    logic [PW-1:0] burst_last;

    // A burst is code_q lit/dark pairs followed by the dark gap.
    assign burst_last = {1'b0, code_q, 1'b0} + GAP_M1;

    always_comb begin
        lit     = lit_q;
        phase_d = phase_q;
        code_d  = code_q;
        hold_d  = hold_q;
        if (mode != mode_q) begin
            phase_d = '0;
            code_d  = code;
            hold_d  = '0;
            case (mode)
                MODE_ON, MODE_SLOW, MODE_FAST: lit = 1'b1;
                MODE_CODE: lit = (code != 4'd0);
                MODE_ACT: begin
                    lit = trigger;
                    if (trigger) hold_d = HOLD;
                end
                default: lit = 1'b0;
            endcase
        end else begin
            case (mode)
                MODE_ON: lit = 1'b1;
                MODE_SLOW: if (tick) begin
                    if (phase_q == SLOW_LAST) begin
                        phase_d = '0;
                        lit     = ~lit_q;
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end
                MODE_FAST: if (tick) lit = ~lit_q;
                MODE_CODE: if (tick) begin
                    if (phase_q == burst_last) begin
                        phase_d = '0;
                        code_d  = code;
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                    lit = (phase_d < {1'b0, code_d, 1'b0}) && !phase_d[0];
                end
                MODE_ACT: begin
                    // Reload beats a same-cycle tick.
                    if (trigger) begin
                        hold_d = HOLD;
                        lit    = 1'b1;
                    end else if (tick && hold_q != 4'd0) begin
                        hold_d = hold_q - 1'b1;
                        lit    = (hold_q != 4'd1);
                    end
                end
                default: lit = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mode_q  <= MODE_OFF;
            phase_q <= '0;
            code_q  <= '0;
            hold_q  <= '0;
            lit_q   <= 1'b0;
        end else begin
            mode_q  <= mode;
            phase_q <= phase_d;
            code_q  <= code_d;
            hold_q  <= hold_d;
            lit_q   <= lit;
        end
    end
endmodule

// File: rtl/led_control_multi.sv
// NUM_LEDS status LED channels sharing one 100 ms tick prescaler, with registered polarity-adjusted pins.
module led_control_multi
    import led_pkg::*;
#(
    parameter int CLOCK_SPEED = 25000000,
    parameter int NUM_LEDS    = 4,
    parameter bit ACTIVE_LOW  = 1'b1,
    parameter int HOLD_TICKS  = 2,
    parameter int GAP_TICKS   = 10
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [3*NUM_LEDS-1:0] mode,
    input  logic [4*NUM_LEDS-1:0] code,
    input  logic [NUM_LEDS-1:0]   trigger,
    output logic [NUM_LEDS-1:0]   LED
);
    localparam int DIV = CLOCK_SPEED / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

    logic [PW-1:0]       pre_q;
    logic                tick;
    logic [NUM_LEDS-1:0] lit;

    assign tick = (pre_q == PRE_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) pre_q <= '0;
        else          pre_q <= tick ? '0 : pre_q + 1'b1;
    end

    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
        led_channel #(
            .HOLD_TICKS (HOLD_TICKS),
            .GAP_TICKS  (GAP_TICKS)
        ) u_ch (
            .clock   (clock),
            .reset_n (reset_n),
            .tick    (tick),
            .mode    (mode[3*i +: 3]),
            .code    (code[4*i +: 4]),
            .trigger (trigger[i]),
            .lit     (lit[i])
        );
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) LED <= {NUM_LEDS{ACTIVE_LOW}};
        else          LED <= lit ^ {NUM_LEDS{ACTIVE_LOW}};
    end
endmodule

// File: tb/tb_led_control_multi.sv
// Randomized bench for led_control_multi against a tick-counting behavioural model.
module tb_led_control_multi;
    import led_pkg::*;

    localparam int NL   = 4;
    localparam int HOLD = 2;
    localparam int GAP  = 10;
    localparam int TPER = 10;

    logic            clock   = 1'b0;
    logic            reset_n = 1'b1;
    logic [3*NL-1:0] mode    = '0;
    logic [4*NL-1:0] code    = '0;
    logic [NL-1:0]   trigger = '0;
    logic [NL-1:0]   LED;

    int vectors     = 0;
    int miscompares = 0;

    led_control_multi #(
        .CLOCK_SPEED (100),
        .NUM_LEDS    (NL),
        .ACTIVE_LOW  (1'b1),
        .HOLD_TICKS  (HOLD),
        .GAP_TICKS   (GAP)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .mode    (mode),
        .code    (code),
        .trigger (trigger),
        .LED     (LED)
    );

    always #5 clock = ~clock;

    // Model: counts ticks since mode entry, burst position, and ticks since last trigger.
    int       n = 0;
    int       k[NL];
    int       pos[NL];
    int       bc[NL];
    int       since[NL];
    bit       armed[NL];
    bit [2:0] mprev[NL];
    bit [2:0] m_cur;
    bit       tk;
    logic [NL-1:0] exp_led = '1;

    function automatic logic model_lit(int i);
        case (mprev[i])
            MODE_ON:   return 1'b1;
            MODE_SLOW: return ((k[i] / SLOW_TICKS) % 2) == 0;
            MODE_FAST: return (k[i] % 2) == 0;
            MODE_CODE: return (pos[i] < 2 * bc[i]) && (pos[i] % 2 == 0);
            MODE_ACT:  return armed[i] && (since[i] < HOLD);
            default:   return 1'b0;
        endcase
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            n = 0;
            for (int i = 0; i < NL; i++) begin
                k[i] = 0; pos[i] = 0; bc[i] = 0; since[i] = 0; armed[i] = 1'b0; mprev[i] = 3'd0;
            end
            exp_led = '1;
        end else begin
            tk = (n % TPER) == TPER - 1;
            for (int i = 0; i < NL; i++) begin
                m_cur = mode[3*i +: 3];
                if (m_cur != mprev[i]) begin
                    k[i] = 0; pos[i] = 0; bc[i] = int'(code[4*i +: 4]);
                    armed[i] = trigger[i]; since[i] = 0;
                end else begin
                    if (tk) begin
                        k[i]++;
                        pos[i]++;
                        if (pos[i] == 2 * bc[i] + GAP) begin
                            pos[i] = 0;
                            bc[i]  = int'(code[4*i +: 4]);
                        end
                    end
                    if (trigger[i]) begin
                        armed[i] = 1'b1; since[i] = 0;
                    end else if (tk) begin
                        since[i]++;
                    end
                end
                mprev[i]   = m_cur;
                exp_led[i] = ~model_lit(i);
            end
            n++;
        end
    end

    task automatic check(input string name, input logic [NL-1:0] act, input logic [NL-1:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clock) if (reset_n) check("led_model", LED, exp_led);

    task automatic wait_align(input int r);
        int t = 0;
        while ((n % TPER) != r && t < 2 * TPER) begin
            @(negedge clock);
            t++;
        end
        vectors++;
        if ((n % TPER) != r) begin
            miscompares++;
            $display("FAIL align: phase %0d expected %0d", n % TPER, r);
        end
    endtask

    task automatic set_mode(input int ch, input logic [2:0] m);
        mode[3*ch +: 3] = m;
    endtask

    task automatic mid_reset();
        @(posedge clock);
        #3 reset_n = 1'b0;
        #1 check("async_reset", LED, 4'hF);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_led", LED, 4'hF);
        reset_n = 1'b1;
        repeat (200) @(negedge clock);
        check("idle_200", LED, 4'hF);

        // Enter all flashing modes right after a tick edge.
        wait_align(0);
        set_mode(0, MODE_ON);
        set_mode(1, MODE_FAST);
        set_mode(2, MODE_SLOW);
        set_mode(3, MODE_CODE);
        code[15:12] = 4'd3;
        @(negedge clock);
        check("enter", LED, 4'b0000);
        repeat (9) @(negedge clock);
        check("tick1", LED, 4'b1010);
        repeat (10) @(negedge clock);
        check("tick2", LED, 4'b0000);
        code[15:12] = 4'd1;
        repeat (30) @(negedge clock);
        check("tick5", LED, 4'b1110);
        repeat (200) @(negedge clock);

        // Activity: pulse, retrigger on a tick cycle, then expiry.
        set_mode(0, MODE_ACT);
        trigger[0] = 1'b1;
        @(negedge clock);
        trigger[0] = 1'b0;
        check("act_on", {3'b000, LED[0]}, 4'b0000);
        wait_align(9);
        trigger[0] = 1'b1;
        @(negedge clock);
        trigger[0] = 1'b0;
        repeat (40) @(negedge clock);
        check("act_expired", {3'b000, LED[0]}, 4'b0001);

        // Reserved modes and FAST -> OFF while lit.
        set_mode(1, 3'd6);
        @(negedge clock);
        check("rsvd6", {3'b000, LED[1]}, 4'b0001);
        set_mode(1, MODE_FAST);
        @(negedge clock);
        check("fast_lit", {3'b000, LED[1]}, 4'b0000);
        set_mode(1, MODE_OFF);
        @(negedge clock);
        check("fast_off", {3'b000, LED[1]}, 4'b0001);
        set_mode(1, 3'd7);
        repeat (5) @(negedge clock);
        check("rsvd7", {3'b000, LED[1]}, 4'b0001);

        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            if ($urandom_range(63) == 0) set_mode(int'($urandom_range(NL - 1)), 3'($urandom_range(7)));
            if ($urandom_range(31) == 0) code[4*$urandom_range(NL - 1) +: 4] = 4'($urandom_range(15));
            for (int i = 0; i < NL; i++) trigger[i] = ($urandom_range(7) == 0);
            if (c % 1000 == 999) mid_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
